sr_drive_ctrl: RTL and testbench

Upstream command stage for the SR flip-flop (SR_FF). It turns raw, asynchronous set/clear request lines into clean, mutually exclusive S/R drive pulses aligned to CLK. The S and R outputs connect directly to SR_FF, and the flip-flop is never presented with S=R=1. The block also keeps a shadow of the expected flip-flop state, suppresses redundant commands, and queues requests that arrive while a drive is in progress.

---
 rtl/sr_drive_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_sr_drive_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
//
// Command stage in front of an SR flip-flop. Raw, asynchronous set/clear
// request levels are synchronized, debounced and turned into rising-edge
// events. An FSM converts these events into clean, mutually exclusive S/R
// drive pulses. It keeps a shadow of the flip-flop state so redundant
// commands are dropped. Requests that arrive while a drive is in flight are
// queued one deep.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized cycles needed to change a debounced
//                     level (1..255)
//   CNT_W           : width of the debounce counters
//   PULSE_CYCLES    : cycles S or R is held high per command (1..15)
//   SET_PRIORITY    : simultaneous set+clear winner (0 = clear, 1 = set)
//
// Ports:
//   CLK      in   system clock, rising edge
//   RST_N    in   asynchronous active-low reset
//   SET_REQ  in   raw set request level (asynchronous)
//   CLR_REQ  in   raw clear request level (asynchronous)
//   S        out  set drive to SR_FF (registered)
//   R        out  reset drive to SR_FF (registered)
//   BUSY     out  high while the FSM is not idle
//   STATE_Q  out  shadow of the expected SR_FF Q
//   CONFLICT out  one-cycle pulse when set and clear coincide in idle
//
// Optional build macro:
//   SR_DRV_CONFLICT_DROP_EN : when defined, a simultaneous set+clear is
//   discarded entirely and only CONFLICT pulses. SET_PRIORITY is ignored.
// -----------------------------------------------------------------------------
module sr_drive_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8,
  parameter int PULSE_CYCLES    = 1,
  parameter int SET_PRIORITY    = 0
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic SET_REQ,
  input  logic CLR_REQ,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic STATE_Q,
  output logic CONFLICT
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       PLS_LAST = 4'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE_S = 2'd1,
    ST_DRIVE_R = 2'd2,
    ST_GAP     = 2'd3
  } state_t;

  // Channel index 0 = set, 1 = clear.
  logic [1:0]       w_req;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_lvl;
  logic [1:0]       r_evt;
  logic [CNT_W-1:0] r_cnt [2];

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_pcnt;
  logic [3:0] w_pcnt_nxt;
  logic       r_pend_s;
  logic       r_pend_c;
  logic       w_pend_s_nxt;
  logic       w_pend_c_nxt;

  logic       r_s;
  logic       r_r;
  logic       r_busy;
  logic       r_state_q;
  logic       r_conflict;
  logic       w_s_nxt;
  logic       w_r_nxt;
  logic       w_busy_nxt;
  logic       w_q_nxt;
  logic       w_conf_nxt;

  logic       w_any_s;
  logic       w_any_c;
  logic       w_win_s;
  logic       w_win_c;
  logic       w_take_s;
  logic       w_take_r;

  assign w_req = {CLR_REQ, SET_REQ};

  // ---------------------------------------------------------------------------
  // Synchronizers and debouncers. The event is registered at the same edge
  // the debounced level flips, so it is visible to the FSM the cycle after.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_lvl    <= '0;
      r_evt    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_req;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        r_evt[i] <= 1'b0;
        if (r_sync2[i] == r_lvl[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DEB_LAST) begin
          r_lvl[i] <= r_sync2[i];
          r_cnt[i] <= '0;
          // Only rising edges of the debounced level become events.
          r_evt[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fresh events and queued requests are treated alike in idle.
  assign w_any_s = r_evt[0] | r_pend_s;
  assign w_any_c = r_evt[1] | r_pend_c;

`ifdef SR_DRV_CONFLICT_DROP_EN
  assign w_win_s = w_any_s & ~w_any_c;
  assign w_win_c = w_any_c & ~w_any_s;
`else
  assign w_win_s = w_any_s & (~w_any_c | (SET_PRIORITY != 0));
  assign w_win_c = w_any_c & (~w_any_s | (SET_PRIORITY == 0));
`endif

  // A winner that matches the current shadow state is redundant and dropped.
  assign w_take_s = w_win_s & ~r_state_q;
  assign w_take_r = w_win_c &  r_state_q;

  // ---------------------------------------------------------------------------
  // FSM state register; outputs are registered decodes of the next state so
  // S and R can never overlap or glitch.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_IDLE;
      r_pcnt     <= '0;
      r_pend_s   <= 1'b0;
      r_pend_c   <= 1'b0;
      r_s        <= 1'b0;
      r_r        <= 1'b0;
      r_busy     <= 1'b0;
      r_state_q  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_pend_s   <= w_pend_s_nxt;
      r_pend_c   <= w_pend_c_nxt;
      r_s        <= w_s_nxt;
      r_r        <= w_r_nxt;
      r_busy     <= w_busy_nxt;
      r_state_q  <= w_q_nxt;
      r_conflict <= w_conf_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt  = r_state;
    w_pcnt_nxt   = r_pcnt;
    w_conf_nxt   = 1'b0;
    // Outside idle, events merge into the one-deep pending flags.
    w_pend_s_nxt = r_pend_s | r_evt[0];
    w_pend_c_nxt = r_pend_c | r_evt[1];
    case (r_state)
      ST_IDLE: begin
        // Everything visible in idle is consumed now: serviced or dropped.
        w_pend_s_nxt = 1'b0;
        w_pend_c_nxt = 1'b0;
        w_conf_nxt   = w_any_s & w_any_c;
        if (w_take_s) begin
          w_state_nxt = ST_DRIVE_S;
          w_pcnt_nxt  = '0;
        end else if (w_take_r) begin
          w_state_nxt = ST_DRIVE_R;
          w_pcnt_nxt  = '0;
        end
      end
      ST_DRIVE_S, ST_DRIVE_R: begin
        if (r_pcnt == PLS_LAST) begin
          w_state_nxt = ST_GAP;
        end else begin
          w_pcnt_nxt = r_pcnt + 1'b1;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output logic (values loaded into the output registers at the next edge).
  always_comb begin
    w_s_nxt    = (w_state_nxt == ST_DRIVE_S);
    w_r_nxt    = (w_state_nxt == ST_DRIVE_R);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_q_nxt    = r_state_q;
    // The shadow flips together with the last drive cycle.
    if (w_s_nxt && (w_pcnt_nxt == PLS_LAST)) begin
      w_q_nxt = 1'b1;
    end else if (w_r_nxt && (w_pcnt_nxt == PLS_LAST)) begin
      w_q_nxt = 1'b0;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign BUSY     = r_busy;
  assign STATE_Q  = r_state_q;
  assign CONFLICT = r_conflict;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
module tb_sr_drive_ctrl;

  logic CLK     = 1'b0;
  logic RST_N   = 1'b1;
  logic SET_REQ = 1'b0;
  logic CLR_REQ = 1'b0;
  logic [2:0] s_o, r_o, busy_o, q_o, conf_o;

  always #5 CLK = ~CLK;

  // a: defaults; b: short debounce, 4-cycle pulse, set priority; c: 8-cycle pulse
  sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .PULSE_CYCLES(1), .SET_PRIORITY(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
    .S(s_o[0]), .R(r_o[0]), .BUSY(busy_o[0]), .STATE_Q(q_o[0]), .CONFLICT(conf_o[0]));
  sr_drive_ctrl #(.DEBOUNCE_CYCLES(3), .CNT_W(8), .PULSE_CYCLES(4), .SET_PRIORITY(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
    .S(s_o[1]), .R(r_o[1]), .BUSY(busy_o[1]), .STATE_Q(q_o[1]), .CONFLICT(conf_o[1]));
  sr_drive_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(8), .PULSE_CYCLES(8), .SET_PRIORITY(0)) dut_c (
    .CLK(CLK), .RST_N(RST_N), .SET_REQ(SET_REQ), .CLR_REQ(CLR_REQ),
    .S(s_o[2]), .R(r_o[2]), .BUSY(busy_o[2]), .STATE_Q(q_o[2]), .CONFLICT(conf_o[2]));

  function automatic int p_deb(int i);
    return (i == 1) ? 3 : 4;
  endfunction
  function automatic int p_pls(int i);
    return (i == 0) ? 1 : ((i == 1) ? 4 : 8);
  endfunction
  function automatic int p_prio(int i);
    return (i == 1) ? 1 : 0;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each command is a time window: decided at edge t, drive after edges
  // t..t+P-1, busy through t+P, next idle decision at edge t+P+2.
  int n;
  int m_s1 [3][2];
  int m_s2 [3][2];
  int m_lvl[3][2];
  int m_run[3][2];
  int m_ev [3][2];
  int m_pend[3][2];
  int m_q[3], m_free[3], m_start[3], m_kind[3], m_conf[3];
  logic [2:0] e_s, e_r, e_busy, e_q, e_conf;

  task automatic model_reset();
    n = 0;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[i][c] = 0; m_s2[i][c] = 0; m_lvl[i][c] = 0;
        m_run[i][c] = 0; m_ev[i][c] = 0; m_pend[i][c] = 0;
      end
      m_q[i] = 0; m_free[i] = 0; m_start[i] = -100; m_kind[i] = 0; m_conf[i] = -100;
    end
    e_s = '0; e_r = '0; e_busy = '0; e_q = '0; e_conf = '0;
  endtask

  task automatic model_step(int i, int xs, int xc);
    int as, ac, p, x, old;
    p = p_pls(i);
    if (n >= m_free[i]) begin
      as = m_ev[i][0] | m_pend[i][0];
      ac = m_ev[i][1] | m_pend[i][1];
      m_pend[i][0] = 0;
      m_pend[i][1] = 0;
      if (as != 0 && ac != 0) begin
        m_conf[i] = n;
`ifdef SR_DRV_CONFLICT_DROP_EN
        as = 0; ac = 0;
`else
        if (p_prio(i) != 0) ac = 0; else as = 0;
`endif
      end
      if (as != 0 && m_q[i] == 0) begin
        m_kind[i] = 1; m_start[i] = n; m_free[i] = n + p + 2;
      end else if (ac != 0 && m_q[i] != 0) begin
        m_kind[i] = 2; m_start[i] = n; m_free[i] = n + p + 2;
      end
    end else begin
      m_pend[i][0] = m_pend[i][0] | m_ev[i][0];
      m_pend[i][1] = m_pend[i][1] | m_ev[i][1];
    end
    e_s[i]    = (m_kind[i] == 1) && (n >= m_start[i]) && (n < m_start[i] + p);
    e_r[i]    = (m_kind[i] == 2) && (n >= m_start[i]) && (n < m_start[i] + p);
    e_busy[i] = (m_kind[i] != 0) && (n >= m_start[i]) && (n <= m_start[i] + p);
    if (m_kind[i] != 0 && n == m_start[i] + p - 1) m_q[i] = (m_kind[i] == 1) ? 1 : 0;
    e_q[i]    = (m_q[i] != 0);
    e_conf[i] = (m_conf[i] == n);
    // A level flips after DEB consecutive synchronized samples disagreeing with it.
    for (int c = 0; c < 2; c++) begin
      x   = (c == 0) ? xs : xc;
      old = m_s2[i][c];
      m_ev[i][c] = 0;
      if (old != m_lvl[i][c]) begin
        m_run[i][c]++;
        if (m_run[i][c] == p_deb(i)) begin
          m_lvl[i][c] = old; m_run[i][c] = 0; m_ev[i][c] = old;
        end
      end else begin
        m_run[i][c] = 0;
      end
      m_s2[i][c] = m_s1[i][c];
      m_s1[i][c] = x;
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) model_reset();
    else begin
      for (int i = 0; i < 3; i++) model_step(i, int'(SET_REQ), int'(CLR_REQ));
      n++;
    end
  end

  // Single compare process, mid-cycle.
  always @(negedge CLK) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("S[%0d]", i),        int'(s_o[i]),    int'(e_s[i]));
        check($sformatf("R[%0d]", i),        int'(r_o[i]),    int'(e_r[i]));
        check($sformatf("BUSY[%0d]", i),     int'(busy_o[i]), int'(e_busy[i]));
        check($sformatf("STATE_Q[%0d]", i),  int'(q_o[i]),    int'(e_q[i]));
        check($sformatf("CONFLICT[%0d]", i), int'(conf_o[i]), int'(e_conf[i]));
        check($sformatf("excl[%0d]", i),     int'(s_o[i] & r_o[i]), 0);
      end
    end
  end

  task automatic wait_count(input int ncyc, input int i,
                            inout int cs, inout int cr, inout int cb, inout int cc);
    repeat (ncyc) begin
      @(negedge CLK);
      cs += int'(s_o[i]); cr += int'(r_o[i]);
      cb += int'(busy_o[i]); cc += int'(conf_o[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cs, cr, cb, cc, first_r, last_s, tot, d, v, hit;
    bit drop;
`ifdef SR_DRV_CONFLICT_DROP_EN
    drop = 1'b1;
`else
    drop = 1'b0;
`endif
    #1 RST_N = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_S", int'(s_o[0]), 0);
    check("rst_R", int'(r_o[0]), 0);
    check("rst_BUSY", int'(busy_o[0]), 0);
    check("rst_STATE_Q", int'(q_o[0]), 0);
    check("rst_CONFLICT", int'(conf_o[0]), 0);
    @(negedge CLK); #2 RST_N = 1'b1;

    // First set: S on the 7th edge, BUSY for 2 cycles.
    @(negedge CLK); SET_REQ = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(posedge CLK); #1;
      check($sformatf("first_S_e%0d", k), int'(s_o[0]), (k == 7) ? 1 : 0);
      check($sformatf("first_BUSY_e%0d", k), int'(busy_o[0]), (k == 7 || k == 8) ? 1 : 0);
      check($sformatf("first_Q_e%0d", k), int'(q_o[0]), (k >= 7) ? 1 : 0);
      check($sformatf("first_R_e%0d", k), int'(r_o[0]), 0);
    end

    // Redundant set while STATE_Q=1.
    @(negedge CLK); SET_REQ = 1'b0;
    repeat (12) @(negedge CLK);
    SET_REQ = 1'b1;
    cs = 0; cr = 0; cb = 0; cc = 0;
    wait_count(14, 0, cs, cr, cb, cc);
    check("redundant_S", cs, 0);
    check("redundant_BUSY", cb, 0);

    // Bouncing clear request never gets through.
    cs = 0; cr = 0; cb = 0; cc = 0;
    for (int j = 0; j < 10; j++) begin
      CLR_REQ = ~CLR_REQ;
      wait_count(2, 0, cs, cr, cb, cc);
    end
    wait_count(6, 0, cs, cr, cb, cc);
    check("bounce_R", cr, 0);
    check("bounce_BUSY", cb, 0);
    check("bounce_Q", int'(q_o[0]), 1);

    // Simultaneous set+clear with STATE_Q=1.
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    repeat (12) @(negedge CLK);
    SET_REQ = 1'b1; CLR_REQ = 1'b1;
    cs = 0; cr = 0; cb = 0; cc = 0;
    wait_count(14, 0, cs, cr, cb, cc);
    check("conflict_pulses", cc, 1);
    check("conflict_R", cr, drop ? 0 : 1);
    check("conflict_S", cs, 0);
    check("conflict_Q", int'(q_o[0]), drop ? 1 : 0);

    // Bring every instance to STATE_Q=0.
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    repeat (12) @(negedge CLK);
    CLR_REQ = 1'b1;
    repeat (24) @(negedge CLK);
    CLR_REQ = 1'b0;
    repeat (12) @(negedge CLK);

    // Clear arrives while instance b is driving S (4-cycle pulse).
    SET_REQ = 1'b1;
    repeat (2) @(negedge CLK);
    CLR_REQ = 1'b1;
    cs = 0; cr = 0; first_r = -1; last_s = -1;
    for (int j = 0; j < 30; j++) begin
      @(negedge CLK);
      if (s_o[1]) begin cs++; last_s = j; end
      if (r_o[1]) begin cr++; if (first_r < 0) first_r = j; end
    end
    check("queue_S_cycles", cs, 4);
    check("queue_R_cycles", cr, 4);
    check("queue_R_delay", first_r - last_s, 3);
    check("queue_Q", int'(q_o[1]), 0);

    // Reset in the middle of instance c's 8-cycle S pulse.
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    repeat (20) @(negedge CLK);
    SET_REQ = 1'b1;
    cs = 0; hit = 0;
    for (int j = 0; j < 40 && hit == 0; j++) begin
      @(negedge CLK);
      if (s_o[2]) cs++;
      if (cs == 3) hit = 1;
    end
    check("midrst_reached", hit, 1);
    #1 RST_N = 1'b0;
    #1;
    check("midrst_S_async", int'(s_o[2]), 0);
    check("midrst_outputs", int'({s_o, r_o, busy_o, q_o, conf_o}), 0);
    SET_REQ = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST_N = 1'b1;
    cs = 0; cr = 0; cb = 0; cc = 0;
    wait_count(20, 2, cs, cr, cb, cc);
    check("midrst_after_S", cs, 0);
    check("midrst_after_BUSY", cb, 0);

    // Randomized request traffic against the model.
    tot = 0;
    while (tot < 800) begin
      d = $urandom_range(1, 18);
      case ($urandom_range(0, 3))
        0: SET_REQ = ~SET_REQ;
        1: CLR_REQ = ~CLR_REQ;
        2: begin v = $urandom_range(0, 1); SET_REQ = v[0]; CLR_REQ = v[0]; end
        default: ;
      endcase
      repeat (d) @(negedge CLK);
      tot += d;
    end
    SET_REQ = 1'b0; CLR_REQ = 1'b0;
    repeat (30) @(negedge CLK);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
